// File: rtl/movshift_engine.sv
`default_nettype none
// ============================================================================
// Module   : movshift_engine
// Purpose  : Iterative barrel-free shifter for the shifted-register MOV path.
//            Shifts an operand by LSL/LSR/ASR/ROR up to STEP bits per clock
//            and returns the result with the ARM-style shifter carry-out.
// Revision : 1.0 - initial release
// ============================================================================
module movshift_engine #(
   parameter int N    = 32,
   parameter int STEP = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 ready,
   input  logic [N-1:0]         operand,
   input  logic [$clog2(N)-1:0] shamt,
   input  logic [1:0]           shtype,
   input  logic                 carry_in,
   output logic [N-1:0]         result,
   output logic                 carry_out,
   output logic                 valid,
   output logic                 busy
);

   localparam int            W      = $clog2(N);
   localparam logic [W-1:0]  C_STEP = W'(STEP);

   localparam logic [1:0] C_LSL = 2'b00;
   localparam logic [1:0] C_LSR = 2'b01;
   localparam logic [1:0] C_ASR = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t         r_state;
   logic [N-1:0]   r_work;
   logic [W-1:0]   r_rem;
   logic [1:0]     r_type;
   logic           r_carry;
   logic           r_ready;

   logic [W-1:0]   w_k;
   logic [N-1:0]   w_work;
   logic           w_carry;

   // Bits to shift this cycle: the smaller of STEP and what remains
   always_comb begin
      w_k = (r_rem > C_STEP) ? C_STEP : r_rem;
   end

   // Chain of w_k single-bit steps; carry tracks the last bit shifted out,
   // so a multi-bit step is bit-exact with the equivalent single-bit steps
   always_comb begin
      w_work  = r_work;
      w_carry = r_carry;
      for (int j = 0; j < STEP; j++) begin
         if (W'(j) < w_k) begin
            case (r_type)
               C_LSL: begin
                  w_carry = w_work[N-1];
                  w_work  = {w_work[N-2:0], 1'b0};
               end
               C_LSR: begin
                  w_carry = w_work[0];
                  w_work  = {1'b0, w_work[N-1:1]};
               end
               C_ASR: begin
                  w_carry = w_work[0];
                  w_work  = {w_work[N-1], w_work[N-1:1]};
               end
               default: begin
                  w_carry = w_work[0];
                  w_work  = {w_work[0], w_work[N-1:1]};
               end
            endcase
         end
      end
   end

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_work    <= '0;
         r_rem     <= '0;
         r_type    <= '0;
         r_carry   <= 1'b0;
         r_ready   <= 1'b1;
         result    <= '0;
         carry_out <= 1'b0;
         valid     <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_work  <= operand;
                  r_rem   <= shamt;
                  r_type  <= shtype;
                  r_carry <= carry_in;
                  r_ready <= 1'b0;
                  r_state <= (shamt != '0) ? S_SHIFT : S_DONE;
               end
            end
            S_SHIFT: begin
               r_work  <= w_work;
               r_carry <= w_carry;
               r_rem   <= r_rem - w_k;
               if (r_rem <= C_STEP) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               result    <= r_work;
               carry_out <= r_carry;
               valid     <= 1'b1;
               r_ready   <= 1'b1;
               r_state   <= S_IDLE;
            end
            default: begin
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ready = r_ready;
   assign busy  = ~r_ready;

endmodule
`default_nettype wire

// File: tb/tb_movshift_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_movshift_engine
// Purpose  : Directed and model-based checks of movshift_engine for STEP=1
//            and STEP=4 (both N=32), sharing clock, reset and operand inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_movshift_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start1, start4;
   logic [31:0] operand;
   logic [4:0]  shamt;
   logic [1:0]  shtype;
   logic        carry_in;

   logic        ready1, valid1, busy1, cout1;
   logic [31:0] result1;
   logic        ready4, valid4, busy4, cout4;
   logic [31:0] result4;

   int n_checks = 0;
   int n_pass   = 0;

   movshift_engine #(.N(32), .STEP(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .ready(ready1),
      .operand(operand), .shamt(shamt), .shtype(shtype), .carry_in(carry_in),
      .result(result1), .carry_out(cout1), .valid(valid1), .busy(busy1)
   );

   movshift_engine #(.N(32), .STEP(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .ready(ready4),
      .operand(operand), .shamt(shamt), .shtype(shtype), .carry_in(carry_in),
      .result(result4), .carry_out(cout4), .valid(valid4), .busy(busy4)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic get_valid(input int sel);
      return (sel == 1) ? valid1 : valid4;
   endfunction
   function automatic logic get_ready(input int sel);
      return (sel == 1) ? ready1 : ready4;
   endfunction
   function automatic logic [31:0] get_result(input int sel);
      return (sel == 1) ? result1 : result4;
   endfunction
   function automatic logic get_carry(input int sel);
      return (sel == 1) ? cout1 : cout4;
   endfunction

   // Reference: direct closed-form shift, carry from the defining bit index
   function automatic logic [32:0] ref_shift(input logic [31:0] op, input int s,
                                             input logic [1:0] ty, input logic cin);
      logic [31:0] r;
      logic        c;
      if (s == 0) return {cin, op};
      case (ty)
         2'b00:   begin r = op << s; c = op[32-s]; end
         2'b01:   begin r = op >> s; c = op[s-1];  end
         2'b10:   begin r = $unsigned($signed(op) >>> s); c = op[s-1]; end
         default: begin r = (op >> s) | (op << (32 - s)); c = r[31]; end
      endcase
      return {c, r};
   endfunction

   task automatic drive_start(input int sel, input logic [31:0] op, input logic [4:0] sh,
                              input logic [1:0] ty, input logic cin);
      @(negedge clk);
      operand  = op;
      shamt    = sh;
      shtype   = ty;
      carry_in = cin;
      if (sel == 1) start1 = 1'b1; else start4 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      start4 = 1'b0;
      // Disturb inputs after acceptance; they must have no effect
      operand = ~op;
      shamt   = ~sh;
      shtype  = ~ty;
      carry_in = ~cin;
   endtask

   task automatic do_op(input int sel, input logic [31:0] op, input logic [4:0] sh,
                        input logic [1:0] ty, input logic cin, input logic [31:0] exp_r,
                        input logic exp_c, input int exp_lat, input string tag);
      int  edges = 0;
      int  rlow  = 0;
      bit  got   = 0;
      drive_start(sel, op, sh, ty, cin);
      if (!get_ready(sel)) rlow++;
      while (!got && edges < 200) begin
         @(posedge clk);
         edges++;
         #1;
         if (get_valid(sel)) got = 1;
         else if (!get_ready(sel)) rlow++;
      end
      check({tag, "_latency"}, edges, exp_lat);
      check({tag, "_ready_low"}, rlow, exp_lat);
      check({tag, "_result"}, get_result(sel), exp_r);
      check({tag, "_carry"}, {31'd0, get_carry(sel)}, {31'd0, exp_c});
      @(posedge clk);
      #1;
      check({tag, "_valid_pulse"}, {31'd0, get_valid(sel)}, 32'd0);
   endtask

   initial begin
      int nv;
      logic [31:0] rop;
      logic [4:0]  rsh;
      logic [1:0]  rty;
      logic        rci;
      logic [32:0] exp;

      rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0;
      operand = '0; shamt = '0; shtype = '0; carry_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready",  {31'd0, ready1}, 32'd1);
      check("rst_busy",   {31'd0, busy1},  32'd0);
      check("rst_valid",  {31'd0, valid1}, 32'd0);
      check("rst_result", result1, 32'h0);
      check("rst_carry",  {31'd0, cout1}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed STEP=1 vectors
      do_op(1, 32'h0000_0001, 5'd4,  2'b00, 1'b1, 32'h0000_0010, 1'b0, 5,  "lsl4");
      do_op(1, 32'h0000_0003, 5'd1,  2'b01, 1'b0, 32'h0000_0001, 1'b1, 2,  "lsr1");
      do_op(1, 32'hDEAD_BEEF, 5'd0,  2'b10, 1'b1, 32'hDEAD_BEEF, 1'b1, 1,  "zero");
      do_op(1, 32'h8000_0000, 5'd31, 2'b10, 1'b1, 32'hFFFF_FFFF, 1'b0, 32, "asr31");
      do_op(1, 32'h0000_0001, 5'd1,  2'b11, 1'b0, 32'h8000_0000, 1'b1, 2,  "ror1");
      do_op(1, 32'h1234_5678, 5'd16, 2'b11, 1'b1, 32'h5678_1234, 1'b0, 17, "ror16");

      // Mid-operation reset during a 20-bit shift
      drive_start(1, 32'h0000_0001, 5'd20, 2'b00, 1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_ready",  {31'd0, ready1}, 32'd1);
      check("midrst_busy",   {31'd0, busy1},  32'd0);
      check("midrst_valid",  {31'd0, valid1}, 32'd0);
      check("midrst_result", result1, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      nv = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (valid1) nv++;
      end
      check("midrst_no_valid", nv, 0);

      // Start while busy is ignored
      drive_start(1, 32'h0000_00FF, 5'd8, 2'b00, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      operand = 32'hFFFF_FFFF; shamt = 5'd1; start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      nv = 0;
      while (!valid1 && nv < 200) begin
         @(posedge clk);
         nv++;
         #1;
      end
      check("busy_valid_seen", {31'd0, valid1}, 32'd1);
      check("busy_result", result1, 32'h0000_FF00);
      check("busy_carry",  {31'd0, cout1}, 32'd0);
      @(negedge clk);
      operand = 32'hA5A5_A5A5; shamt = 5'd0; shtype = 2'b00; carry_in = 1'b0; start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      check("busy_valid_single", {31'd0, valid1}, 32'd0);
      check("next_accepted", {31'd0, ready1}, 32'd0);
      @(posedge clk);
      #1;
      check("next_valid",  {31'd0, valid1}, 32'd1);
      check("next_result", result1, 32'hA5A5_A5A5);

      // Directed STEP=4 vectors
      do_op(4, 32'h0000_0001, 5'd7,  2'b00, 1'b0, 32'h0000_0080, 1'b0, 3, "s4_lsl7");
      do_op(4, 32'h8000_0000, 5'd31, 2'b01, 1'b1, 32'h0000_0001, 1'b0, 9, "s4_lsr31");
      do_op(4, 32'hF000_000F, 5'd6,  2'b11, 1'b0, 32'h3FC0_0000, 1'b0, 3, "s4_ror6");

      // Random sweep against the closed-form model, both STEP values
      for (int i = 0; i < 12; i++) begin
         rop = $urandom;
         rsh = 5'($urandom_range(0, 31));
         rty = 2'($urandom_range(0, 3));
         rci = 1'($urandom_range(0, 1));
         exp = ref_shift(rop, int'(rsh), rty, rci);
         do_op(1, rop, rsh, rty, rci, exp[31:0], exp[32],
               (rsh == 0) ? 1 : int'(rsh) + 1, "rnd_s1");
         do_op(4, rop, rsh, rty, rci, exp[31:0], exp[32],
               (int'(rsh) + 3) / 4 + 1, "rnd_s4");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
